elevator_call_dispatcher: RTL
=============================

// Module: elevator_call_dispatcher
// PURPOSE
//  Request-side counterpart of the elevator controller FSM: latches floor call buttons and
//  drives the controller's requested_floor input. Watches current_floor/moving_up/moving_down/
//  door_open from the controller, clears calls as they are served, orders service by SCAN
//  (keep direction while calls remain ahead, then reverse). Sits between button I/O and controller.
// PARAMETERS
//  NUM_FLOORS  4   number of floors; call_btn/pending_calls width
//  FLOOR_W     2   floor index width; NUM_FLOORS <= 2**FLOOR_W
// PORTS
//  clk              in   1           rising-edge clock
//  reset            in   1           synchronous, active-high reset
//  call_btn         in   NUM_FLOORS  call button per floor, level; any cycle high registers a call
//  current_floor    in   FLOOR_W     from controller
//  moving_up        in   1           from controller
//  moving_down      in   1           from controller
//  door_open        in   1           from controller
//  requested_floor  out  FLOOR_W     target floor to controller (registered)
//  pending_calls    out  NUM_FLOORS  latched outstanding calls (registered)
//  busy             out  1           |pending_calls
//  served_pulse     out  1           1-cycle pulse per pending call cleared
//  dir_up           out  1           current SCAN direction (1 = up)
// BEHAVIOUR
//  One clock; reset is synchronous and active-high. Reset (any cycle, incl. mid-trip): state=PARK,
//   dir_up=1, pending_calls=0, requested_floor=0, served_pulse=0, busy=0.
//  stopped = door_open & ~moving_up & ~moving_down. upd = stopped (update window).
//  Pending bit i next = (pending[i] | call_btn[i]) & ~clr[i], clr[i] = stopped & (current_floor==i).
//   Clear wins: call at current floor while stopped is absorbed, never latched.
//   Call at current floor while moving/door closed is latched, served at next stop there.
//  served_pulse = 1 the cycle after a set pending bit is cleared (button-only absorb: no pulse).
//  Latency: call_btn high cycle N -> pending bit cycle N+1 -> requested_floor valid N+2 if upd.
//  requested_floor only changes on cycles with upd=1; frozen while door closing or moving so
//   controller direction/stop compare never sees a moving target.
//  Selection (combinational on registered pending, current_floor; current floor excluded):
//   above = nearest pending > current; below = nearest pending < current.
//  FSM (evaluated only when upd=1; otherwise hold state/outputs except pending/served):
//   PARK: above&below -> nearer wins, tie -> UP; only above -> UP; only below -> DOWN; none -> PARK.
//   UP:   above -> UP, req=above; else below -> DOWN, req=below, dir_up=0; else PARK.
//   DOWN: below -> DOWN, req=below; else above -> UP, req=above, dir_up=1; else PARK.
//   PARK: requested_floor = current_floor (controller stays idle); dir_up held.
//  Floor index >= NUM_FLOORS never produced; call_btn bits above NUM_FLOORS-1 do not exist.
//  All outputs registered except busy (decoded from register).
// TESTING
//  1 Reset, floor 0 stopped, pulse call_btn=4'b0100 1 cycle -> pending=0100 next cycle,
//    requested_floor=2 following cycle, state UP; on stop at 2 pending=0, served_pulse 1 cycle.
//  2 Car moving_up 0->3, press call_btn[1] mid-trip -> requested_floor stays 3 until door_open at 3;
//    then requested_floor=1, dir_up=0, pending[1] stays set until stop at 1.
//  3 SCAN: stopped at 1, dir_up=1, pending 0 and 3 -> requested 3 first, then 0; never 0 first.
//  4 Stopped at 2 with door open, call_btn[2] held 5 cycles -> pending[2] never set, no served_pulse,
//    requested_floor=2, state PARK.
//  5 PARK at 1, calls 0 and 2 same cycle -> tie -> requested_floor=2, dir_up=1.
//  6 Reset asserted while moving with pending=1011 -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/elevator_call_dispatcher.sv
// ----------------------------------------------------------------------------
// elevator_call_dispatcher
//
// Purpose:
//   This is the request side of the elevator controller. It latches the floor
//   call buttons and picks the next target floor for the controller. Floors
//   are served in SCAN order: the car keeps its direction while calls remain
//   ahead of it, then reverses. A call is cleared when the car stands at that
//   floor with its door open.
//
// Ports:
//   clk_i             rising-edge clock
//   reset_i           synchronous, active-high reset
//   call_btn_i        call button per floor, level sensitive
//   current_floor_i   car position reported by the controller
//   moving_up_i       controller reports that the car is moving up
//   moving_down_i     controller reports that the car is moving down
//   door_open_i       controller reports that the door is open
//   requested_floor_o target floor for the controller (registered)
//   pending_calls_o   latched outstanding calls (registered)
//   busy_o            high while any call is pending
//   served_pulse_o    one-cycle pulse for each pending call that is cleared
//   dir_up_o          current SCAN direction (1 = up)
// ----------------------------------------------------------------------------
module elevator_call_dispatcher #(
    parameter int NUM_FLOORS = 4,
    parameter int FLOOR_W    = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [NUM_FLOORS-1:0] call_btn_i,
    input  logic [FLOOR_W-1:0]    current_floor_i,
    input  logic                  moving_up_i,
    input  logic                  moving_down_i,
    input  logic                  door_open_i,
    output logic [FLOOR_W-1:0]    requested_floor_o,
    output logic [NUM_FLOORS-1:0] pending_calls_o,
    output logic                  busy_o,
    output logic                  served_pulse_o,
    output logic                  dir_up_o
);

    typedef enum logic [1:0] {
        ST_PARK = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [FLOOR_W-1:0]    req_q, req_d;
    logic                  dir_up_q, dir_up_d;
    logic                  served_q, served_d;

    logic                  stopped;
    logic [NUM_FLOORS-1:0] clr;
    logic                  above_vld, below_vld;
    logic [FLOOR_W-1:0]    above_flr, below_flr;
    logic [FLOOR_W-1:0]    up_dist, dn_dist;
    logic                  take_up, take_down;

    // The target is only allowed to change while the car stands with its door
    // open. This keeps the target fixed while the controller compares against it.
    assign stopped = door_open_i & ~moving_up_i & ~moving_down_i;

    // Nearest pending call strictly above and strictly below the car.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        above_vld = 1'b0;
        above_flr = '0;
        below_vld = 1'b0;
        below_flr = '0;
        // Scan downwards so the last hit is the lowest floor above the car.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && (i > int'(current_floor_i))) begin
                above_vld = 1'b1;
                above_flr = FLOOR_W'(i);
            end
        end
        // Scan upwards so the last hit is the highest floor below the car.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i] && (i < int'(current_floor_i))) begin
                below_vld = 1'b1;
                below_flr = FLOOR_W'(i);
            end
        end
    end

    assign up_dist = above_flr - current_floor_i;
    assign dn_dist = current_floor_i - below_flr;

    // Going up wins when the car is already heading up, when nothing lies
    // below, or when parked and the call above is no farther than the one
    // below (a tie goes up). In every other case a call below is taken.
    assign take_up   = above_vld & ((state_q == ST_UP) | ~below_vld |
                                    ((state_q == ST_PARK) & (up_dist <= dn_dist)));
    assign take_down = below_vld & ~take_up;

    // Pending calls: a stop at a floor clears that floor's call. The clear has
    // priority over a button press on the same floor, so that press is
    // absorbed and never latched.
    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            clr[i] = stopped & (int'(current_floor_i) == i);
        end
        pending_d = (pending_q | call_btn_i) & ~clr;
        served_d  = |(pending_q & clr);
    end

    // SCAN state machine. It is evaluated only while the car is stopped.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        dir_up_d = dir_up_q;
        if (stopped) begin
            if (take_up) begin
                state_d  = ST_UP;
                req_d    = above_flr;
                dir_up_d = 1'b1;
            end else if (take_down) begin
                state_d  = ST_DOWN;
                req_d    = below_flr;
                dir_up_d = 1'b0;
            end else begin
                state_d  = ST_PARK;
                req_d    = current_floor_i;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. All registers
    // update together at the clock edge, with no ordering races between blocks.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_PARK;
            pending_q <= '0;
            req_q     <= '0;
            dir_up_q  <= 1'b1;
            served_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            req_q     <= req_d;
            dir_up_q  <= dir_up_d;
            served_q  <= served_d;
        end
    end

    assign requested_floor_o = req_q;
    assign pending_calls_o   = pending_q;
    assign busy_o            = |pending_q;
    assign served_pulse_o    = served_q;
    assign dir_up_o          = dir_up_q;

endmodule
